pe1x1_accum: RTL

Output-side consumer for the 1x1 convolution PE array. Takes the packed, registered per-lane products from the PE, one input channel per beat, and accumulates CH_NUM beats per output pixel group in signed fixed point. Presents each completed group on a valid/ready output toward the output feature-map buffer. Back-pressures the PE issue scheduler through `ready_o`, and absorbs the single beat that is already in flight through the PE pipeline in a one-entry skid register.

---
 rtl/pe1x1_accum.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pe1x1_accum.sv
// pe1x1_accum: accumulates CH_NUM channel beats per pixel group across OUTPUT_NUM lanes, with a one-entry skid and a valid/ready output.
// Define PE1X1_ACCUM_SAT_EN for saturating lane adds; otherwise adds wrap modulo 2^W.
module pe1x1_accum #(
   parameter int OUTPUT_NUM = 7,
   parameter int IW         = 24,
   parameter int FW         = 8,
   parameter int CH_NUM     = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [OUTPUT_NUM*(IW+FW)-1:0]  res_i,
   input  logic                           res_valid_i,
   output logic                           ready_o,
   output logic [OUTPUT_NUM*(IW+FW)-1:0]  acc_o,
   output logic                           acc_valid_o,
   input  logic                           acc_ready_i
);

   localparam int W  = IW + FW;
   localparam int BW = OUTPUT_NUM * W;
   localparam int CW = $clog2(CH_NUM);

   typedef enum logic {ST_ACC, ST_HOLD} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_ch_cnt;
   logic [BW-1:0]   r_acc;
   logic [BW-1:0]   r_skid;
   logic            r_skid_vld;
   logic [BW-1:0]   r_out;
   logic            r_out_vld;
   logic [BW-1:0]   w_sum;
   logic            w_last;
   logic            w_out_free;

   function automatic logic [W-1:0] lane_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] s;
      s = a + b;
`ifdef PE1X1_ACCUM_SAT_EN
      // Same-sign operands with a differently-signed result is the only overflow case.
      if ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1]))
         s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
      return s;
   endfunction

   assign w_last     = (r_ch_cnt == CW'(CH_NUM - 1));
   assign w_out_free = !r_out_vld || acc_ready_i;

   always_comb begin
      w_sum = '0;
      for (int k = 0; k < OUTPUT_NUM; k++) begin
         if (r_ch_cnt == '0)
            w_sum[k*W +: W] = res_i[k*W +: W];
         else
            w_sum[k*W +: W] = lane_add(r_acc[k*W +: W], res_i[k*W +: W]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_ACC;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ACC:  if (res_valid_i && w_last && !w_out_free) w_state_nxt = ST_HOLD;
         ST_HOLD: if (acc_ready_i) w_state_nxt = ST_ACC;
         default: w_state_nxt = ST_ACC;
      endcase
   end

   always_comb begin
      ready_o = !rst && (r_state == ST_ACC) && !r_skid_vld;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc      <= '0;
         r_ch_cnt   <= '0;
         r_skid     <= '0;
         r_skid_vld <= 1'b0;
         r_out      <= '0;
         r_out_vld  <= 1'b0;
      end else begin
         if (acc_ready_i)
            r_out_vld <= 1'b0;
         if (r_state == ST_ACC) begin
            if (res_valid_i) begin
               if (w_last) begin
                  r_ch_cnt <= '0;
                  if (w_out_free) begin
                     r_out     <= w_sum;
                     r_out_vld <= 1'b1;
                  end else begin
                     r_acc <= w_sum;
                  end
               end else begin
                  r_acc    <= w_sum;
                  r_ch_cnt <= r_ch_cnt + CW'(1);
               end
            end
         end else begin
            // HOLD: the held sum moves out on drain, and the next group's first beat seeds acc.
            if (acc_ready_i) begin
               r_out     <= r_acc;
               r_out_vld <= 1'b1;
               if (r_skid_vld) begin
                  r_acc      <= r_skid;
                  r_ch_cnt   <= CW'(1);
                  r_skid_vld <= 1'b0;
               end else if (res_valid_i) begin
                  r_acc    <= res_i;
                  r_ch_cnt <= CW'(1);
               end
            end else if (res_valid_i) begin
               r_skid     <= res_i;
               r_skid_vld <= 1'b1;
            end
         end
      end
   end

   assign acc_o       = r_out;
   assign acc_valid_o = r_out_vld;

endmodule
